matrix_bram_arbiter: RTL and testbench
======================================

// Module: matrix_bram_arbiter
// PURPOSE
//  Shares the single matrix-storage BRAM read port among up to NUM_REQ requesters
//  (matrix_scanner, matrix_reader, compute-unit operand fetchers). Round-robin
//  grant with optional burst lock and fixed-latency read return routed to the
//  issuing requester. Replaces the priority address mux in the operand-selection path.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  ADDR_WIDTH  14   BRAM word address width
//  DATA_WIDTH  32   BRAM data width
//  RD_LATENCY  1    BRAM read latency in cycles, addr/en to data (1..3)
// PORTS
//  clk         in   1                     system clock
//  rst         in   1                     synchronous, active-high reset
//  req         in   NUM_REQ               per-requester access request, level
//  lock        in   NUM_REQ               per-requester burst hold, qualified by req
//  req_addr    in   NUM_REQ*ADDR_WIDTH    packed addresses; requester i uses slice i
//  gnt         out  NUM_REQ               registered one-hot grant
//  rd_valid    out  NUM_REQ               one-hot strobe: rd_data belongs to requester i
//  rd_data     out  DATA_WIDTH            read data, broadcast to all requesters
//  bram_en     out  1                     BRAM read enable
//  bram_addr   out  ADDR_WIDTH            BRAM read address
//  bram_data   in   DATA_WIDTH            BRAM read data
//  busy        out  1                     gnt != 0 or any read in flight
// BEHAVIOUR
//  Reset: gnt=0, rd_valid=0, bram_en=0, bram_addr=0, rd_data=0, busy=0, state=ARB_IDLE,
//   rr pointer=0, in-flight pipeline cleared. Reset mid-burst drops all pending returns.
//  States: ARB_IDLE -> ARB_GRANT -> ARB_RELEASE -> ARB_IDLE.
//  ARB_IDLE: if req!=0, pick first set bit searching from rr_ptr upward with wrap;
//   gnt<=onehot(pick), owner<=pick, go ARB_GRANT. Grant latency: 1 cycle after req.
//  ARB_GRANT: access issued in every cycle where req[owner]=1:
//   bram_en=1, bram_addr=req_addr[owner] (combinational from registered owner).
//   Stay while req[owner]&&lock[owner]. If req[owner]&&!lock[owner]: issue this one
//   access, then ARB_RELEASE. If req[owner]=0: no access, ARB_RELEASE.
//   Owner dropping req in its first granted cycle is legal: zero accesses, release.
//  ARB_RELEASE: gnt<=0, rr_ptr<=owner+1 (mod NUM_REQ), go ARB_IDLE. Results in one idle
//   bus cycle between owners; a continuously requesting non-locked requester gets at
//   most one access per 3 cycles while others wait (fairness over throughput).
//  Return path: RD_LATENCY-deep shift register of {valid, owner id}, loaded on every
//   issued access. At depth RD_LATENCY: rd_valid<=onehot(id) if valid, rd_data<=bram_data.
//   Return cycle = issue cycle + RD_LATENCY + 1 (registered output). Returns in flight
//   at release are still delivered to the original owner, even after gnt moves on.
//  Requests from non-owners are ignored until ARB_IDLE; no preemption, no starvation:
//   every requester holding req is granted within NUM_REQ arbitration rounds.
//  lock is ignored when req is low. req_addr of non-owners is don't-care.
//  bram_en=0 and bram_addr=0 whenever no access is issued (no stray reads).
//  busy=1 from grant until last in-flight rd_valid has been emitted.
// STRUCTURE
//  Package matrix_bram_arb_pkg: arb_state_t {ARB_IDLE, ARB_GRANT, ARB_RELEASE};
//   localparam ARB_MAX_REQ=8; function onehot_id(id) helper.
//  Sub-module rr_pick (combinational): inputs req, rr_ptr; outputs found, pick index.
//  Top holds FSM, owner/rr_ptr registers, address mux and the return shift register.
// TESTING
//  1 Single read: req[1]=1,lock=0,addr=0x0010 -> gnt=4'b0010 next cycle, one bram_en
//    at 0x0010, rd_valid=4'b0010 with rd_data=mem[0x0010] at issue+RD_LATENCY+1.
//  2 Burst: req[0],lock[0] held 9 cycles, addr 0..8 -> 9 consecutive bram_en, 9 returns
//    in order to requester 0; req[2] raised meanwhile granted only after release.
//  3 Round-robin: req=4'b1111 all non-locked, held -> grant order 0,1,2,3,0 with one
//    idle cycle after each access; rr_ptr wraps 3->0.
//  4 Early drop: req[3] drops the cycle gnt[3] rises -> zero bram_en, release, gnt=0.
//  5 Handover in flight (RD_LATENCY=2): requester 0 last access, then requester 1
//    granted -> final return still tagged rd_valid[0], none lost or misrouted.
//  6 Reset mid-burst: rst=1 with 2 reads in flight -> no rd_valid afterwards, all
//    outputs at reset values, next req granted normally.

Source files
------------

// File: rtl/matrix_bram_arb_pkg.sv
// Shared definitions for the matrix BRAM read-port arbiter.
//  arb_state_t  arbiter FSM states
//  ARB_MAX_REQ  largest supported requester count
//  ARB_ID_W     requester id width that covers ARB_MAX_REQ
//  onehot_id()  id -> one-hot vector over ARB_MAX_REQ bits
package matrix_bram_arb_pkg;

   localparam int ARB_MAX_REQ = 8;
   localparam int ARB_ID_W    = 3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

   function automatic logic [ARB_MAX_REQ-1:0] onehot_id(input logic [ARB_ID_W-1:0] id);
      return ARB_MAX_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/matrix_bram_arbiter_rr_pick.sv
// Round-robin picker (combinational).
// Finds the first set request bit searching upward from rr_ptr, wrapping
// past NUM_REQ-1 back to 0.
//  req     in   NUM_REQ   request vector
//  rr_ptr  in   ID_W      search start index (must be < NUM_REQ)
//  found   out  1         at least one request is set
//  pick    out  ID_W      index of the chosen requester (0 when !found)
module rr_pick
   import matrix_bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               found,
   output logic [ID_W-1:0]    pick
);

   localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

   logic [NUM_REQ-1:0] rot;
   logic [ID_W:0]      sum;

   always_comb begin
      // Rotate so that bit 0 of rot is requester rr_ptr; the lowest set bit
      // of rot is then the round-robin winner.
      rot   = NUM_REQ'({req, req} >> rr_ptr);
      found = 1'b0;
      sum   = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
         end
      end
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end
      pick = sum[ID_W-1:0];
   end

endmodule

// File: rtl/matrix_bram_arbiter.sv
// Matrix-storage BRAM read-port arbiter.
// Shares one BRAM read port between NUM_REQ requesters with round-robin
// grant, optional burst lock, and a fixed-latency return path that tags each
// read result with the requester that issued it.
//  clk        in   1                   system clock
//  rst        in   1                   synchronous active-high reset
//  req        in   NUM_REQ             per-requester level request
//  lock       in   NUM_REQ             per-requester burst hold (qualified by req)
//  req_addr   in   NUM_REQ*ADDR_WIDTH  packed addresses, slice i for requester i
//  gnt        out  NUM_REQ             registered one-hot grant
//  rd_valid   out  NUM_REQ             one-hot: rd_data belongs to requester i
//  rd_data    out  DATA_WIDTH          registered read data, broadcast
//  bram_en    out  1                   BRAM read enable
//  bram_addr  out  ADDR_WIDTH          BRAM read address (0 when idle)
//  bram_data  in   DATA_WIDTH          BRAM read data, RD_LATENCY after en
//  busy       out  1                   grant held or any read still in flight
module matrix_bram_arbiter
   import matrix_bram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          bram_en,
   output logic [ADDR_WIDTH-1:0]         bram_addr,
   input  logic [DATA_WIDTH-1:0]         bram_data,
   output logic                          busy
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t            state;
   logic [ID_W-1:0]       owner;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       pick;
   logic                  found;
   logic                  issue;
   logic                  any_inflight;
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

   // Return-path pipeline: one {valid, id} entry per BRAM latency cycle.
   logic                  vld_p [RD_LATENCY];
   logic [ID_W-1:0]       id_p  [RD_LATENCY];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
      assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .found  (found),
      .pick   (pick)
   );

   // An access goes out only while the owner keeps its request up; the
   // address is forced to 0 otherwise so the BRAM never sees stray reads.
   always_comb begin
      issue        = (state == ARB_GRANT) && req[owner];
      bram_en      = issue;
      bram_addr    = issue ? addr_arr[owner] : '0;
      any_inflight = 1'b0;
      for (int k = 0; k < RD_LATENCY; k++) begin
         any_inflight = any_inflight | vld_p[k];
      end
      busy = (|gnt) | any_inflight | (|rd_valid);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB_IDLE;
         gnt    <= '0;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (found) begin
                  gnt   <= NUM_REQ'(onehot_id(ARB_ID_W'(pick)));
                  owner <= pick;
                  state <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               // Unlocked owner gets this single access; dropped req gets none.
               if (!(req[owner] && lock[owner])) begin
                  state <= ARB_RELEASE;
               end
            end
            ARB_RELEASE: begin
               gnt    <= '0;
               rr_ptr <= (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + ID_W'(1);
               state  <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Stage p0..p(RD_LATENCY-1): track issued accesses alongside the BRAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            vld_p[k] <= 1'b0;
         end
      end else begin
         vld_p[0] <= issue;
         for (int k = 1; k < RD_LATENCY; k++) begin
            vld_p[k] <= vld_p[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      id_p[0] <= owner;
      for (int k = 1; k < RD_LATENCY; k++) begin
         id_p[k] <= id_p[k-1];
      end
   end

   // Output stage: route data to the id that issued it, even if the grant
   // has already moved on to another requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= vld_p[RD_LATENCY-1] ?
                     NUM_REQ'(onehot_id(ARB_ID_W'(id_p[RD_LATENCY-1]))) : '0;
         if (vld_p[RD_LATENCY-1]) begin
            rd_data <= bram_data;
         end
      end
   end

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
module tb_matrix_bram_arbiter;

   localparam int N  = 4;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int L  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rd_valid;
   logic [DW-1:0]   rd_data;
   logic            bram_en;
   logic [AW-1:0]   bram_addr;
   logic [DW-1:0]   bram_data;
   logic            busy;

   matrix_bram_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .lock      (lock),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .bram_en   (bram_en),
      .bram_addr (bram_addr),
      .bram_data (bram_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      return (32'(a) * 32'h0001_0003) ^ 32'h5A00_00C3;
   endfunction

   // BRAM: data for an address presented with en appears L cycles later.
   logic [DW-1:0] bpipe [L];
   always @(posedge clk) begin
      bpipe[0] <= bram_en ? mem(bram_addr) : 32'hDEAD_BEEF;
      for (int k = 1; k < L; k++) bpipe[k] <= bpipe[k-1];
   end
   assign bram_data = bpipe[L-1];

   // Reference model: who holds the port, whether it may still access,
   // round-robin start point, and a queue of expected returns with due cycles.
   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } ret_t;
   ret_t rq[$];
   int   m_owner;
   bit   m_active;
   int   m_ptr;
   int   cyc;

   int            n_assert;
   int            n_fail;
   int            n_en;
   int            n_en_by [N];
   int            n_ret [N];
   int            iss_cyc;
   int            ret_cyc;
   logic [DW-1:0] last_data;
   int            order[$];
   logic [N-1:0]  prev_gnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_model(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   task automatic clr();
      n_en = 0;
      for (int i = 0; i < N; i++) begin
         n_en_by[i] = 0;
         n_ret[i]   = 0;
      end
      order.delete();
   endtask

   task automatic cycle();
      logic [N-1:0]  exp_gnt;
      logic          exp_en;
      logic [AW-1:0] exp_addr;
      logic [N-1:0]  exp_rv;
      logic [DW-1:0] exp_data;
      logic          exp_busy;
      int            p;
      @(negedge clk);
      exp_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      exp_en   = (m_owner >= 0) && m_active && req[m_owner];
      exp_addr = exp_en ? req_addr[m_owner*AW +: AW] : '0;
      exp_busy = (exp_gnt != 0) || (rq.size() != 0);
      exp_rv   = '0;
      exp_data = '0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
         exp_rv   = N'(1) << rq[0].id;
         exp_data = rq[0].data;
      end
      chk("gnt",       64'(gnt),       64'(exp_gnt));
      chk("bram_en",   64'(bram_en),   64'(exp_en));
      chk("bram_addr", 64'(bram_addr), 64'(exp_addr));
      chk("rd_valid",  64'(rd_valid),  64'(exp_rv));
      if (exp_rv != 0) chk("rd_data", 64'(rd_data), 64'(exp_data));
      chk("busy",      64'(busy),      64'(exp_busy));
      if (exp_rv != 0) void'(rq.pop_front());
      if (exp_en) rq.push_back('{due: cyc + L + 1, id: m_owner, data: mem(exp_addr)});
      if (bram_en) begin
         n_en++;
         iss_cyc = cyc;
         if (m_owner >= 0) n_en_by[m_owner]++;
      end
      for (int i = 0; i < N; i++) begin
         if (rd_valid[i]) begin
            n_ret[i]++;
            ret_cyc   = cyc;
            last_data = rd_data;
         end
      end
      if (gnt != 0 && prev_gnt == 0) begin
         for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
      end
      prev_gnt = gnt;
      @(posedge clk);
      if (rst) begin
         m_owner  = -1;
         m_active = 1'b0;
         m_ptr    = 0;
         rq.delete();
      end else if (m_owner < 0) begin
         p = rr_model(req, m_ptr);
         if (p >= 0) begin
            m_owner  = p;
            m_active = 1'b1;
         end
      end else if (m_active) begin
         if (!(req[m_owner] && lock[m_owner])) m_active = 1'b0;
      end else begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end
      cyc++;
      #1;
   endtask

   int exp_ord [5] = '{0, 1, 2, 3, 0};

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0;
      m_owner = -1; m_active = 1'b0; m_ptr = 0;
      iss_cyc = 0; ret_cyc = 0; last_data = '0; prev_gnt = '0;
      rst = 1'b1; req = '0; lock = '0; req_addr = '0;
      clr();
      @(posedge clk); #1;
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_gnt",       64'(gnt),       64'h0);
      chk("rst_rd_valid",  64'(rd_valid),  64'h0);
      chk("rst_bram_en",   64'(bram_en),   64'h0);
      chk("rst_bram_addr", 64'(bram_addr), 64'h0);
      chk("rst_rd_data",   64'(rd_data),   64'h0);
      chk("rst_busy",      64'(busy),      64'h0);

      // Single read by requester 1
      clr();
      req = 4'b0010; set_addr(1, 14'h0010);
      cycle();
      chk("t1_gnt",  64'(gnt),       64'h2);
      chk("t1_en",   64'(bram_en),   64'h1);
      chk("t1_addr", 64'(bram_addr), 64'h10);
      cycle();
      req = '0;
      repeat (5) cycle();
      chk("t1_n_en",   64'(n_en),              64'd1);
      chk("t1_n_ret",  64'(n_ret[1]),          64'd1);
      chk("t1_lat",    64'(ret_cyc - iss_cyc), 64'(L + 1));
      chk("t1_data",   64'(last_data),         64'(mem(14'h0010)));

      // Locked burst of 9 by requester 0, requester 2 waits
      clr();
      req = 4'b0001; lock = 4'b0001; set_addr(0, 14'h0);
      cycle();
      for (int k = 0; k < 9; k++) begin
         set_addr(0, AW'(k));
         if (k == 8) lock = '0;
         if (k == 2) begin
            req[2] = 1'b1;
            set_addr(2, 14'h0200);
         end
         cycle();
      end
      req[0] = 1'b0;
      cycle();
      cycle();
      chk("t2_gnt2", 64'(gnt), 64'h4);
      cycle();
      req = '0;
      repeat (6) cycle();
      chk("t2_en0",   64'(n_en_by[0]),   64'd9);
      chk("t2_ret0",  64'(n_ret[0]),     64'd9);
      chk("t2_en2",   64'(n_en_by[2]),   64'd1);
      chk("t2_ret2",  64'(n_ret[2]),     64'd1);
      chk("t2_nord",  64'(order.size()), 64'd2);
      chk("t2_ord0",  64'(order[0]),     64'd0);
      chk("t2_ord1",  64'(order[1]),     64'd2);

      // Early drop by requester 3
      clr();
      req = 4'b1000; set_addr(3, 14'h0333);
      cycle();
      chk("t4_gnt3", 64'(gnt), 64'h8);
      req = '0;
      cycle();
      cycle();
      chk("t4_gnt0", 64'(gnt),  64'h0);
      chk("t4_n_en", 64'(n_en), 64'd0);

      // Round robin, all requesting, none locked
      clr();
      req = 4'b1111; lock = '0;
      for (int i = 0; i < N; i++) set_addr(i, AW'(14'h0100 + i));
      repeat (15) cycle();
      req = '0;
      repeat (6) cycle();
      chk("t3_nord", 64'(order.size()), 64'd5);
      for (int i = 0; i < 5; i++) chk("t3_order", 64'(order[i]), 64'(exp_ord[i]));
      chk("t3_n_en", 64'(n_en), 64'd5);
      chk("t3_ret0", 64'(n_ret[0]), 64'd2);
      chk("t3_ret3", 64'(n_ret[3]), 64'd1);

      // Handover with a return still in flight
      clr();
      req = 4'b0001; lock = 4'b0001; set_addr(0, 14'h0040);
      cycle();
      cycle();
      set_addr(0, 14'h0041); lock = '0;
      req = 4'b0011; set_addr(1, 14'h0050);
      cycle();
      req = 4'b0010;
      cycle();
      cycle();
      chk("t5_gnt1", 64'(gnt),      64'h2);
      chk("t5_rv0",  64'(rd_valid), 64'h1);
      chk("t5_data", 64'(rd_data),  64'(mem(14'h0041)));
      cycle();
      req = '0;
      repeat (6) cycle();
      chk("t5_ret0", 64'(n_ret[0]), 64'd2);
      chk("t5_ret1", 64'(n_ret[1]), 64'd1);

      // Reset with two reads in flight
      req = 4'b0001; lock = 4'b0001; set_addr(0, 14'h0060);
      cycle();
      cycle();
      set_addr(0, 14'h0061);
      cycle();
      rst = 1'b1; req = '0; lock = '0;
      clr();
      cycle();
      rst = 1'b0;
      chk("t6_gnt",   64'(gnt),       64'h0);
      chk("t6_rv",    64'(rd_valid),  64'h0);
      chk("t6_en",    64'(bram_en),   64'h0);
      chk("t6_addr",  64'(bram_addr), 64'h0);
      chk("t6_data",  64'(rd_data),   64'h0);
      chk("t6_busy",  64'(busy),      64'h0);
      repeat (5) cycle();
      chk("t6_noret", 64'(n_ret[0] + n_ret[1] + n_ret[2] + n_ret[3]), 64'd0);
      req = 4'b0100; set_addr(2, 14'h0222);
      cycle();
      chk("t6_gnt2", 64'(gnt), 64'h4);
      cycle();
      req = '0;
      repeat (6) cycle();
      chk("t6_ret2", 64'(n_ret[2]), 64'd1);

      // Random traffic against the model
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         lock = N'($urandom);
         for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
         cycle();
      end
      req = '0; lock = '0;
      repeat (8) cycle();
      chk("end_busy", 64'(busy), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
